fsm_general_param: RTL and testbench

FSM_GENERAL_PARAM -- requirements
Module: fsm_general_param

---
 rtl/fsm_general_pkg.sv | 7 +
 rtl/sync_2ff.sv | 12 +
 rtl/fsm_general_param.sv | 104 ++++++++++
 tb/tb_fsm_general_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_general_pkg.sv
// fsm_general_pkg: state encoding and default parameters for fsm_general_param
package fsm_general_pkg;
  typedef enum logic [2:0] {IDLE, INIT, DECIDE, WRITE, READ, GAP} state_t;
  localparam int NUM_CH_DEF  = 4;
  localparam int GAP_CYC_DEF = 16;
  localparam int TO_CYC_DEF  = 1024;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous level input
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (!reset) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/fsm_general_param.sv
// fsm_general_param: init/write/read channel sequencer with idle gap between passes
// FSM_GENERAL_TIMEOUT_EN adds a watchdog on every wait state that re-initialises the device
module fsm_general_param
  import fsm_general_pkg::*;
#(
  parameter int  NUM_CH  = NUM_CH_DEF,
  parameter int  GAP_CYC = GAP_CYC_DEF,
  parameter int  TO_CYC  = TO_CYC_DEF,
  localparam int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            Iniciar,
  input  logic            Buttom_SW,
  input  logic            BandFin,
  input  logic            Bandfin_wr,
  input  logic            Bandfin_rd,
  output logic            inicializacion,
  output logic            Inicio_Escritura,
  output logic            Inicio_Lectura,
  output logic [CH_W-1:0] ch_sel,
  output logic            seq_done,
  output logic            err_timeout
);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  if (NUM_CH < 1 || NUM_CH > 256 || GAP_CYC < 1 || GAP_CYC > 65535 || TO_CYC < 2 || TO_CYC > 65535)
    $error("fsm_general_param: parameter out of range");
  state_t state, nxt;
  logic [CH_W-1:0] ch_nxt;
  logic [15:0] gap_cnt;
  logic sw, done;
`ifdef FSM_GENERAL_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic waiting, awaited, to_hit;
`endif
  sync_2ff u_sync (.clk(CLK), .reset(reset), .d(Buttom_SW), .q(sw));
  always_comb begin
    nxt = state;
    ch_nxt = ch_sel;
    done = 1'b0;
    case (state)
      IDLE:   nxt = INIT;
      INIT:   nxt = BandFin ? DECIDE : INIT;
      DECIDE: begin
        nxt = sw ? WRITE : READ;
        ch_nxt = '0;
      end
      WRITE, READ:
        if (state == WRITE ? Bandfin_wr : Bandfin_rd) begin
          done = ch_sel == LAST_CH;
          nxt = done ? GAP : state;
          ch_nxt = done ? '0 : ch_sel + CH_W'(1);
        end
      GAP:     nxt = gap_cnt == 16'(GAP_CYC - 1) ? DECIDE : GAP;
      default: nxt = IDLE;
    endcase
`ifdef FSM_GENERAL_TIMEOUT_EN
    waiting = state inside {INIT, WRITE, READ};
    awaited = state == INIT ? BandFin : state == WRITE ? Bandfin_wr : state == READ ? Bandfin_rd : 1'b0;
    to_hit = waiting && !awaited && wd_cnt == 16'(TO_CYC - 1);
    if (to_hit) begin
      nxt = INIT;
      ch_nxt = '0;
    end
`endif
    // dropping the enable overrides every other event this cycle
    if (!Iniciar) begin
      nxt = IDLE;
      ch_nxt = '0;
      done = 1'b0;
    end
  end
  always_ff @(posedge CLK)
    if (!reset) begin
      state <= IDLE;
      ch_sel <= '0;
      gap_cnt <= '0;
      seq_done <= 1'b0;
      inicializacion <= 1'b0;
      Inicio_Escritura <= 1'b0;
      Inicio_Lectura <= 1'b0;
    end else begin
      state <= nxt;
      ch_sel <= ch_nxt;
      seq_done <= done;
      inicializacion <= nxt == INIT;
      Inicio_Escritura <= nxt == WRITE;
      Inicio_Lectura <= nxt == READ;
      gap_cnt <= state == GAP && nxt == GAP ? gap_cnt + 16'd1 : '0;
    end
`ifdef FSM_GENERAL_TIMEOUT_EN
  // each awaited strobe restarts the budget, so every channel gets a full TO_CYC window
  always_ff @(posedge CLK)
    if (!reset) begin
      wd_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= (nxt != state || to_hit || awaited || !waiting) ? '0 : wd_cnt + 16'd1;
      err_timeout <= Iniciar && (err_timeout || to_hit);
    end
`else
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_fsm_general_param.sv
// tb_fsm_general_param: scheduled-transaction checks of the channel sequencer
module tb_fsm_general_param;
  localparam int NCH = 4, GAP_N = 16, TO_N = 8;
  logic CLK = 0, reset = 0, Iniciar = 0, Buttom_SW = 0, BandFin = 0, Bandfin_wr = 0, Bandfin_rd = 0;
  logic inicializacion, Inicio_Escritura, Inicio_Lectura, seq_done, err_timeout;
  logic [1:0] ch_sel;
  logic [6:0] obs, exp_v;
  bit err_exp = 0;
  int tests = 0, fails = 0;
  always #5 CLK = ~CLK;
  fsm_general_param #(.NUM_CH(NCH), .GAP_CYC(GAP_N), .TO_CYC(TO_N)) dut (
    .CLK(CLK), .reset(reset), .Iniciar(Iniciar), .Buttom_SW(Buttom_SW), .BandFin(BandFin),
    .Bandfin_wr(Bandfin_wr), .Bandfin_rd(Bandfin_rd), .inicializacion(inicializacion),
    .Inicio_Escritura(Inicio_Escritura), .Inicio_Lectura(Inicio_Lectura), .ch_sel(ch_sel),
    .seq_done(seq_done), .err_timeout(err_timeout)
  );
  assign obs = {inicializacion, Inicio_Escritura, Inicio_Lectura, ch_sel, seq_done, err_timeout};
  // expected output word: {init, write, read, ch_sel, seq_done, err_timeout}
  function automatic logic [6:0] pk(bit i, bit w, bit r, int ch, bit d, bit e);
    return {i, w, r, 2'(ch), d, e};
  endfunction
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  // from INIT: settle the switch, pulse BandFin, expect DECIDE then the chosen mode at channel 0
  task automatic start(bit mode);
    Buttom_SW = mode;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_v = pk(1, 0, 0, 0, 0, err_exp);
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL start_init[%0d]: got %b want %b", k, obs, exp_v); end
    end
    BandFin = 1;
    step();
    BandFin = 0;
    exp_v = pk(0, 0, 0, 0, 0, err_exp);
    tests++; if (obs !== exp_v) begin fails++; $display("FAIL start_decide: got %b want %b", obs, exp_v); end
    step();
    exp_v = pk(0, mode, !mode, 0, 0, err_exp);
    tests++; if (obs !== exp_v) begin fails++; $display("FAIL start_mode: got %b want %b", obs, exp_v); end
  endtask
  // one full pass from channel 0 of mode; the switch flips to next_mode mid-pass and must only take effect after GAP
  task automatic do_pass(bit mode, bit next_mode);
    for (int c = 0; c < NCH; c++) begin
      int w = $urandom_range(0, 3);
      if (c == 1) Buttom_SW = next_mode;
      for (int k = 0; k < w; k++) begin
        Bandfin_wr = mode ? 1'b0 : 1'($urandom_range(0, 1));
        Bandfin_rd = mode ? 1'($urandom_range(0, 1)) : 1'b0;
        BandFin = 1'($urandom_range(0, 1));
        step();
        exp_v = pk(0, mode, !mode, c, 0, err_exp);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL pass_wait ch%0d: got %b want %b", c, obs, exp_v); end
      end
      Bandfin_wr = mode;
      Bandfin_rd = !mode;
      BandFin = 0;
      step();
      Bandfin_wr = 0;
      Bandfin_rd = 0;
      exp_v = c < NCH - 1 ? pk(0, mode, !mode, c + 1, 0, err_exp) : pk(0, 0, 0, 0, 1, err_exp);
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL pass_advance ch%0d: got %b want %b", c, obs, exp_v); end
    end
    // GAP_N-1 further GAP cycles then one DECIDE cycle, all silent
    for (int k = 0; k < GAP_N; k++) begin
      step();
      exp_v = pk(0, 0, 0, 0, 0, err_exp);
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL pass_gap[%0d]: got %b want %b", k, obs, exp_v); end
    end
    step();
    exp_v = pk(0, next_mode, !next_mode, 0, 0, err_exp);
    tests++; if (obs !== exp_v) begin fails++; $display("FAIL pass_next_mode: got %b want %b", obs, exp_v); end
  endtask
  task automatic test_reset();
    reset = 0;
    Iniciar = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (obs !== 7'b0) begin fails++; $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, 7'b0); end
    end
    reset = 1;
    step();
    exp_v = pk(1, 0, 0, 0, 0, 0);
    tests++; if (obs !== exp_v) begin fails++; $display("FAIL reset_release_init: got %b want %b", obs, exp_v); end
  endtask
  task automatic test_write_pass();
    start(1);
    do_pass(1, 0);
  endtask
  task automatic test_switch_midpass();
    do_pass(0, 1);
  endtask
  task automatic test_ignore_rd();
    for (int k = 0; k < 3; k++) begin
      Bandfin_rd = 1;
      step();
      Bandfin_rd = 0;
      exp_v = pk(0, 1, 0, 0, 0, 0);
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL ignore_rd[%0d]: got %b want %b", k, obs, exp_v); end
    end
    do_pass(1, 1);
  endtask
  task automatic test_abort(int at);
    for (int c = 0; c < at; c++) begin
      Bandfin_wr = 1;
      step();
      Bandfin_wr = 0;
      exp_v = pk(0, 1, 0, c + 1, 0, 0);
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL abort_adv ch%0d: got %b want %b", c, obs, exp_v); end
    end
    Iniciar = 0;
    Bandfin_wr = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      Bandfin_wr = 0;
      tests++; if (obs !== 7'b0) begin fails++; $display("FAIL abort_idle at%0d[%0d]: got %b want %b", at, k, obs, 7'b0); end
    end
    Iniciar = 1;
    step();
    exp_v = pk(1, 0, 0, 0, 0, 0);
    tests++; if (obs !== exp_v) begin fails++; $display("FAIL abort_restart: got %b want %b", obs, exp_v); end
    start(1);
  endtask
  task automatic test_reset_midpass();
    for (int c = 0; c < NCH - 1; c++) begin
      Bandfin_wr = 1;
      step();
      Bandfin_wr = 0;
    end
    reset = 0;
    Bandfin_wr = 1;
    step();
    Bandfin_wr = 0;
    tests++; if (obs !== 7'b0) begin fails++; $display("FAIL reset_midpass: got %b want %b", obs, 7'b0); end
    reset = 1;
    step();
    exp_v = pk(1, 0, 0, 0, 0, 0);
    tests++; if (obs !== exp_v) begin fails++; $display("FAIL reset_midpass_init: got %b want %b", obs, exp_v); end
    start(1);
  endtask
  task automatic test_timeout();
    do_pass(1, 0);
`ifdef FSM_GENERAL_TIMEOUT_EN
    for (int k = 0; k < TO_N - 1; k++) begin
      step();
      exp_v = pk(0, 0, 1, 0, 0, 0);
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL to_wait0[%0d]: got %b want %b", k, obs, exp_v); end
    end
    Bandfin_rd = 1;
    step();
    Bandfin_rd = 0;
    exp_v = pk(0, 0, 1, 1, 0, 0);
    tests++; if (obs !== exp_v) begin fails++; $display("FAIL to_strobe_wins: got %b want %b", obs, exp_v); end
    for (int k = 0; k < TO_N - 1; k++) begin
      step();
      exp_v = pk(0, 0, 1, 1, 0, 0);
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL to_wait1[%0d]: got %b want %b", k, obs, exp_v); end
    end
    step();
    err_exp = 1;
    exp_v = pk(1, 0, 0, 0, 0, 1);
    tests++; if (obs !== exp_v) begin fails++; $display("FAIL to_fire: got %b want %b", obs, exp_v); end
    for (int k = 0; k < 10; k++) begin
      step();
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL to_sticky[%0d]: got %b want %b", k, obs, exp_v); end
    end
    start(0);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      exp_v = pk(0, 0, 1, 0, 0, 0);
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL no_watchdog[%0d]: got %b want %b", k, obs, exp_v); end
    end
`endif
    Iniciar = 0;
    step();
    err_exp = 0;
    tests++; if (obs !== 7'b0) begin fails++; $display("FAIL to_clear: got %b want %b", obs, 7'b0); end
    Iniciar = 1;
    step();
    exp_v = pk(1, 0, 0, 0, 0, 0);
    tests++; if (obs !== exp_v) begin fails++; $display("FAIL to_restart: got %b want %b", obs, exp_v); end
    start(1);
  endtask
  task automatic test_random();
    bit m = 1;
    for (int p = 0; p < 8; p++) begin
      bit n = 1'($urandom_range(0, 1));
      do_pass(m, n);
      m = n;
    end
  endtask
  initial begin
    test_reset();
    test_write_pass();
    test_switch_midpass();
    test_ignore_rd();
    test_abort(2);
    test_abort(3);
    test_reset_midpass();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
